// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM with a mult/div wait state
module mc_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int ALUOP_W     = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [31:0]        i_instr,
    input  logic               i_zero,
    output logic               o_irwe,
    output logic               o_pcwe,
    output logic [1:0]         o_npcop,
    output logic [1:0]         o_wrsel,
    output logic [1:0]         o_wdsel,
    output logic               o_rfwe,
    output logic [1:0]         o_extop,
    output logic [1:0]         o_asel,
    output logic [1:0]         o_bsel,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic               o_dmwe,
    output logic               o_md_start,
    output logic               o_md_op,
    output logic               o_hilo_sel,
    output logic               o_md_busy,
    output logic               o_instr_done,
    output logic [2:0]         o_state
);
    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W  = $clog2(MD_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic w_rtype, w_addu, w_subu, w_sll, w_jr, w_mult, w_div, w_mfhi, w_mflo;
    logic w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic w_known, w_wb_class, w_decode_retire;

    assign w_op    = i_instr[31:26];
    assign w_funct = i_instr[5:0];
    // The all-zero word is a nop here, not sll $0,$0,0, so it is excluded from R-type.
    assign w_rtype = (w_op == 6'b000000) && (|i_instr);
    assign w_addu  = w_rtype && (w_funct == 6'b100001);
    assign w_subu  = w_rtype && (w_funct == 6'b100011);
    assign w_jr    = w_rtype && (w_funct == 6'b001000);
    assign w_sll   = w_rtype && (w_funct == 6'b000000);
    assign w_mult  = w_rtype && (w_funct == 6'b011000);
    assign w_div   = w_rtype && (w_funct == 6'b011010);
    assign w_mfhi  = w_rtype && (w_funct == 6'b010000);
    assign w_mflo  = w_rtype && (w_funct == 6'b010010);
    assign w_ori   = (w_op == 6'b001101);
    assign w_lw    = (w_op == 6'b100011);
    assign w_sw    = (w_op == 6'b101011);
    assign w_beq   = (w_op == 6'b000100);
    assign w_lui   = (w_op == 6'b001111);
    assign w_jal   = (w_op == 6'b000011);
    assign w_j     = (w_op == 6'b000010);

    assign w_wb_class = w_addu | w_subu | w_sll | w_ori | w_lui | w_mfhi | w_mflo;
    assign w_known    = w_wb_class | w_jr | w_mult | w_div | w_lw | w_sw | w_beq | w_j | w_jal;
    assign w_decode_retire = w_j | w_jal | w_jr | ~w_known;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: r_state <= w_decode_retire ? S_FETCH : S_EXEC;
                S_EXEC: begin
                    if (w_wb_class) begin
                        r_state <= S_WB;
                    end else if (w_lw || w_sw) begin
                        r_state <= S_MEM;
                    end else if (w_mult || w_div) begin
                        r_cnt   <= w_div ? DIV_LD : MULT_LD;
                        r_state <= S_MDWAIT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEM:    r_state <= w_lw ? S_WB : S_FETCH;
                S_WB:     r_state <= S_FETCH;
                S_MDWAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        o_irwe     = 1'b0;
        o_pcwe     = 1'b0;
        o_rfwe     = 1'b0;
        o_dmwe     = 1'b0;
        o_md_start = 1'b0;
        o_md_busy  = 1'b0;
        o_npcop    = 2'd0;
        o_wrsel    = 2'd0;
        o_wdsel    = 2'd0;
        o_extop    = 2'd0;
        o_asel     = 2'd0;
        o_bsel     = 2'd0;
        o_aluop    = '0;
        o_md_op    = 1'b0;
        o_hilo_sel = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                S_FETCH:  o_irwe = 1'b1;
                S_DECODE: begin
                    o_pcwe = w_decode_retire;
                    o_rfwe = w_jal;
                end
                S_EXEC: begin
                    o_pcwe     = w_beq;
                    o_md_start = w_mult | w_div;
                end
                S_MEM: begin
                    o_dmwe = w_sw;
                    o_pcwe = w_sw;
                end
                S_WB: begin
                    o_rfwe = 1'b1;
                    o_pcwe = 1'b1;
                end
                S_MDWAIT: begin
                    o_md_busy = 1'b1;
                    o_pcwe    = (r_cnt == '0);
                end
                default: ;
            endcase
            // IR is not valid during FETCH, so selects only follow decode afterwards.
            if (r_state != S_FETCH) begin
                if (w_j || w_jal)                          o_npcop = 2'd2;
                else if (w_jr)                             o_npcop = 2'd3;
                else if (w_beq && r_state == S_EXEC && i_zero) o_npcop = 2'd1;
                if (w_jal)                                 o_wrsel = 2'd2;
                else if (w_rtype)                          o_wrsel = 2'd1;
                if (w_lw)                                  o_wdsel = 2'd1;
                else if (w_mfhi || w_mflo)                 o_wdsel = 2'd3;
                else if (w_jal)                            o_wdsel = 2'd2;
                o_extop = {1'b0, w_lw | w_sw | w_beq};
                o_asel  = {1'b0, w_sll};
                o_bsel  = {1'b0, w_ori | w_lui | w_lw | w_sw};
                if (w_subu || w_beq)                       o_aluop = ALUOP_W'(1);
                else if (w_ori)                            o_aluop = ALUOP_W'(2);
                else if (w_lui)                            o_aluop = ALUOP_W'(3);
                else if (w_sll)                            o_aluop = ALUOP_W'(5);
                o_md_op    = w_div;
                o_hilo_sel = w_mfhi;
            end
        end
        o_instr_done = o_pcwe;
    end

    assign o_state = r_state;
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller
module tb_mc_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        irwe, pcwe, rfwe, dmwe, md_start, md_op, hilo_sel, md_busy, instr_done;
    logic [1:0]  npcop, wrsel, wdsel, extop, asel, bsel;
    logic [4:0]  aluop;
    logic [2:0]  state;

    mc_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10), .ALUOP_W(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_zero(zero),
        .o_irwe(irwe), .o_pcwe(pcwe), .o_npcop(npcop), .o_wrsel(wrsel),
        .o_wdsel(wdsel), .o_rfwe(rfwe), .o_extop(extop), .o_asel(asel),
        .o_bsel(bsel), .o_aluop(aluop), .o_dmwe(dmwe), .o_md_start(md_start),
        .o_md_op(md_op), .o_hilo_sel(hilo_sel), .o_md_busy(md_busy),
        .o_instr_done(instr_done), .o_state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int lat, npc, rfn, wrsel, wdsel, hilo, dmn, busyn, startn, mdop, alu, bsel, asel, extop;
        longint trace;
    } vec_t;

    vec_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     n_retired = 0;
    int     n_viol = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: accumulates per-instruction observations and scores them on retirement.
    initial begin
        int cyc, n_rf, n_dm, n_busy, n_start, n_irwe, seen_mdop, c_wr, c_wd, c_hl;
        longint trace;
        vec_t e;
        cyc = 0; n_rf = 0; n_dm = 0; n_busy = 0; n_start = 0; n_irwe = 0;
        seen_mdop = 0; c_wr = 0; c_wd = 0; c_hl = 0; trace = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; n_rf = 0; n_dm = 0; n_busy = 0; n_start = 0; n_irwe = 0; trace = 0;
            end else begin
                if (state == 3'd0 && irwe) begin
                    cyc = 0; n_rf = 0; n_dm = 0; n_busy = 0; n_start = 0; n_irwe = 0; trace = 0;
                end
                cyc++;
                trace = trace * 8 + longint'(state);
                n_irwe  += int'(irwe);
                n_dm    += int'(dmwe);
                n_busy  += int'(md_busy);
                if (md_start) begin
                    n_start++;
                    seen_mdop = int'(md_op);
                end
                if (rfwe) begin
                    n_rf++;
                    c_wr = int'(wrsel); c_wd = int'(wdsel); c_hl = int'(hilo_sel);
                end
                if (instr_done !== pcwe) n_viol++;
                if (irwe && pcwe) n_viol++;
                if (pcwe) begin
                    if (sb.size() == 0) begin
                        chk("spurious_retire", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("latency", cyc, e.lat);
                        chk("npcop", npcop, e.npc);
                        chk("aluop", aluop, e.alu);
                        chk("bsel", bsel, e.bsel);
                        chk("asel", asel, e.asel);
                        chk("extop", extop, e.extop);
                        chk("irwe_count", n_irwe, 1);
                        chk("rfwe_count", n_rf, e.rfn);
                        chk("dmwe_count", n_dm, e.dmn);
                        chk("md_busy_count", n_busy, e.busyn);
                        chk("md_start_count", n_start, e.startn);
                        if (e.trace != 0) chk("state_trace", trace, e.trace);
                        if (e.rfn > 0) begin
                            chk("wrsel", c_wr, e.wrsel);
                            chk("wdsel", c_wd, e.wdsel);
                            chk("hilo_sel", c_hl, e.hilo);
                        end
                        if (e.startn > 0) chk("md_op", seen_mdop, e.mdop);
                    end
                    n_retired++;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int want;
        sb.push_back(v);
        instr = v.instr;
        zero  = v.zero;
        want  = n_retired + 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (n_retired >= want) break;
        end
        chk("retired", n_retired, want);
    endtask

    vec_t vecs[18];

    initial begin
        //          instr         z lat npc rf wr wd hl dm bz st mo alu b a e trace
        vecs[0]  = '{32'h00221821, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h54};
        vecs[1]  = '{32'h8C220004, 0, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 64'h29C};
        vecs[2]  = '{32'hAC220004, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 64'h53};
        vecs[3]  = '{32'h10220003, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 64'hA};
        vecs[4]  = '{32'h10220003, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 64'hA};
        vecs[5]  = '{32'h0C000010, 0, 2, 2, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1};
        vecs[6]  = '{32'h03E00008, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1};
        vecs[7]  = '{32'h00220018, 0, 8, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 64'd351085};
        vecs[8]  = '{32'h0022001A, 0, 13, 0, 0, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 64'd11504376685};
        vecs[9]  = '{32'h00001810, 0, 4, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h54};
        vecs[10] = '{32'h00001812, 0, 4, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h54};
        vecs[11] = '{32'h34220005, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 64'h54};
        vecs[12] = '{32'h3C011234, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 64'h54};
        vecs[13] = '{32'h00021080, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 64'h54};
        vecs[14] = '{32'h08000010, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1};
        vecs[15] = '{32'h00000000, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1};
        vecs[16] = '{32'hFC000000, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1};
        vecs[17] = '{32'h00221823, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 64'h54};

        rst_n = 1'b0;
        instr = 32'h00221821;
        zero  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", state, 0);
        chk("reset_strobes", {irwe, pcwe, rfwe, dmwe, md_start, md_busy, instr_done}, 0);
        chk("reset_selects", {npcop, wrsel, wdsel, extop, asel, bsel, aluop, md_op, hilo_sel}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        // Reset lands in the third MDWAIT cycle of a mult and must abandon it at once.
        instr = 32'h00220018;
        zero  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (state == 3'd5) break;
        end
        chk("mdwait_entered", state, 5);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("mdwait_third_busy", md_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", state, 0);
        chk("async_reset_strobes", {irwe, pcwe, rfwe, dmwe, md_start, md_busy, instr_done}, 0);
        @(posedge clk); #1;
        chk("held_reset_state", state, 0);
        chk("held_reset_strobes", {irwe, pcwe, rfwe, dmwe, md_start, md_busy, instr_done}, 0);
        rst_n = 1'b1;
        run_vec(vecs[15]);
        run_vec(vecs[0]);
        run_vec(vecs[9]);

        chk("pcwe_irwe_done_rules", n_viol, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle successor to the single-cycle decoder: an FSM that sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB, asserting datapath strobes per state.
- Adds multiply/divide support: a parametrised-latency wait state with a down-counter, plus an md_start handshake and an HI/LO writeback path.
- Sits between the instruction register (IR) and the multi-cycle datapath (PC, IR, GRF, ALU, DM, MD unit).

Parameters:
- MULT_CYCLES, 5, cycles spent in MDWAIT for mult (must be >=1)
- DIV_CYCLES, 10, cycles spent in MDWAIT for div (must be >=1)
- ALUOP_W, 5, width of the aluop output

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- instr  in  32  current IR contents (valid from DECODE onward)
- zero  in  1  ALU equality flag (rs==rt), sampled in EXEC
- irwe  out  1  IR write enable
- pcwe  out  1  PC write enable; PC <= NPC(npcop)
- npcop  out  2  0=PC+4, 1=branch, 2=j/jal target, 3=rs
- wrsel  out  2  0=rt, 1=rd, 2=$31
- wdsel  out  2  0=ALU, 1=DM, 2=PC+4, 3=HI/LO
- rfwe  out  1  GRF write enable
- extop  out  2  0=zero-extend, 1=sign-extend
- asel  out  2  0=rs, 1=shamt
- bsel  out  2  0=rt, 1=ext(imm)
- aluop  out  ALUOP_W  0=add, 1=sub, 2=or, 3=lui, 4=A, 5=B<<A
- dmwe  out  1  DM write enable
- md_start  out  1  one-cycle start pulse to the MD unit
- md_op  out  1  0=mult, 1=div; valid while md_start=1
- hilo_sel  out  1  0=LO, 1=HI; meaningful only when wdsel=3
- md_busy  out  1  high in every MDWAIT cycle
- instr_done  out  1  equals pcwe; marks instruction retirement
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5

Behaviour:
- Async reset (reset=0):
  - state=FETCH and the counter is cleared immediately.
  - All strobes are forced to 0 while reset is held: irwe, pcwe, rfwe, dmwe, md_start, md_busy, instr_done.
  - All select outputs and aluop read 0.
  - Releasing reset starts FETCH on the next edge. Reset mid-instruction abandons it; no strobe fires.
- Outputs are combinational from state and instr (Mealy only on zero in EXEC). Non-strobe selects hold their decoded value from DECODE through the final state.
- FETCH: irwe=1 -> DECODE.
- DECODE:
  - j: pcwe=1, npcop=2 -> FETCH.
  - jal: additionally rfwe=1, wrsel=2, wdsel=2.
  - jr: pcwe=1, npcop=3 -> FETCH.
  - all-zero instr and unrecognised opcodes/functs: pcwe=1, npcop=0 -> FETCH (2 cycles, no other strobe).
  - everything else -> EXEC.
- EXEC:
  - addu/subu/sll/ori/lui/mfhi/mflo -> WB.
  - lw/sw -> MEM; aluop=0, bsel=1, extop=1.
  - beq: aluop=1, extop=1, pcwe=1, npcop = zero ? 1 : 0 -> FETCH.
  - mult/div: md_start=1, md_op set, counter <= LAT-1 (LAT = MULT_CYCLES or DIV_CYCLES) -> MDWAIT.
- MEM:
  - sw: dmwe=1, pcwe=1, npcop=0 -> FETCH.
  - lw: -> WB.
- WB:
  - rfwe=1, pcwe=1, npcop=0 -> FETCH.
  - wrsel=1 for R-type, 0 for ori/lui/lw.
  - wdsel=1 for lw, 3 for mfhi/mflo (hilo_sel=1 for mfhi), 0 otherwise.
- MDWAIT:
  - md_busy=1 every cycle.
  - If counter!=0: decrement and stay.
  - If counter==0: pcwe=1, npcop=0 -> FETCH.
  - MDWAIT therefore lasts exactly LAT cycles.
- Instruction latencies (FETCH to retire, inclusive):
  - j/jal/jr/nop: 2
  - beq: 3
  - ALU ops, mfhi/mflo, sw: 4
  - lw: 5
  - mult/div: 3+LAT
- Decode encodings:
  - Opcodes: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, jal 000011, j 000010.
  - Functs (op=0): addu 100001, subu 100011, jr 001000, sll 000000, mult 011000, div 011010, mfhi 010000, mflo 010010.
  - Per-instruction fields: ori uses extop=0, aluop=2, bsel=1. lui uses aluop=3, bsel=1. sll uses asel=1, aluop=5.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1). No wrap: it is only decremented while nonzero.
- Exactly one pcwe pulse per instruction. irwe is never asserted in the same cycle as pcwe.

Test Plan:
- Reset, then addu $3,$1,$2 (0x00221821):
  - states FETCH,DECODE,EXEC,WB.
  - WB cycle has rfwe=1, wrsel=1, wdsel=0, pcwe=1.
  - instr_done pulses once at cycle 4.
- lw then sw:
  - lw 0x8C220004 retires at cycle 5 with wdsel=1 in WB.
  - sw 0xAC220004 asserts dmwe=1 only in MEM and retires at cycle 4.
  - rfwe stays 0 throughout sw.
- beq 0x10220003:
  - with zero=1, EXEC gives pcwe=1, npcop=1.
  - with zero=0, npcop=0.
  - both retire in 3 cycles.
- jal 0x0C000010:
  - DECODE gives rfwe=1, wrsel=2, wdsel=2, npcop=2, pcwe=1.
  - then jr $31 (0x03E00008) gives npcop=3 after 2 cycles.
- mult 0x00220018 (MULT_CYCLES=5):
  - md_start=1, md_op=0 for one cycle.
  - md_busy=1 for exactly 5 cycles; retires at cycle 8.
  - div with DIV_CYCLES=10 retires at cycle 13 with md_op=1.
  - a following mfhi gives wdsel=3, hilo_sel=1, rfwe=1.
- Reset asserted during the 3rd MDWAIT cycle:
  - state=FETCH immediately and all strobes are 0.
  - after release, the next instruction fetches normally and md_busy never reasserts spuriously.
  - 0x00000000 retires in 2 cycles with no rfwe or dmwe.
